// File: rtl/bg_pkg.sv
// Shared background-path definitions: fade FSM states, fade scale and raster constants
// common to the VGA controller, the background mappers and the fade controller.
package bg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VB,
    ST_FADE_OUT,
    ST_SWAP,
    ST_FADE_IN
  } fade_state_e;

  localparam int unsigned FADE_W          = 5;
  localparam int unsigned CHAN_W          = 4;
  localparam logic [4:0]  FADE_FULL       = 5'd16;
  localparam int unsigned H_VISIBLE       = 640;
  localparam int unsigned V_VISIBLE_LINES = 480;

endpackage

// File: rtl/bg_fade_scaler.sv
// Combinational brightness scale for one colour channel: (chan * fade) >> 4.
// fade == 16 passes the channel through unchanged.
module bg_fade_scaler
  import bg_pkg::*;
(
  input  logic [CHAN_W-1:0] chan_in,
  input  logic [FADE_W-1:0] fade,
  output logic [CHAN_W-1:0] chan_c
);

  logic [8:0] prod;

  assign prod   = 9'(chan_in) * 9'(fade);
  assign chan_c = CHAN_W'(prod >> 4);

endmodule

// File: rtl/bg_fade_controller.sv
// Background level sequencer: waits for vertical blank, fades to black, swaps the
// background select, fades back in, and scales the muxed RGB by the current fade.
module bg_fade_controller
  import bg_pkg::*;
#(
  parameter int unsigned NUM_LEVELS      = 4,
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned V_VISIBLE       = V_VISIBLE_LINES,
  parameter int unsigned LVL_W           = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  input  logic             req_valid,
  input  logic [LVL_W-1:0] req_level,
  output logic             req_ready,
  output logic [LVL_W-1:0] bg_sel,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       red_in,
  input  logic [3:0]       green_in,
  input  logic [3:0]       blue_in,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue
);

  localparam int unsigned      CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(NUM_LEVELS - 1);

  fade_state_e       state, state_n;
  logic [FADE_W-1:0] fade, fade_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [LVL_W-1:0]  target, target_n;
  logic [LVL_W-1:0]  bg_sel_n;
  logic              done_n;

  // Frame tick: rising edge of "raster at first non-visible line", so a stalled raster ticks once
  logic vb_cond_c, vb_cond_q, frame_tick_c;

  assign vb_cond_c    = (DrawY == 10'(V_VISIBLE)) && (DrawX == 10'd0);
  assign frame_tick_c = vb_cond_c & ~vb_cond_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) vb_cond_q <= 1'b0;
    else       vb_cond_q <= vb_cond_c;
  end

  logic [LVL_W-1:0] req_clamped_c;

  assign req_clamped_c = (32'(req_level) > 32'(NUM_LEVELS - 1)) ? LVL_MAX : req_level;

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    fade_n   = fade;
    cnt_n    = cnt;
    target_n = target;
    bg_sel_n = bg_sel;
    done_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          target_n = req_clamped_c;
          if (req_clamped_c == bg_sel) done_n  = 1'b1;
          else                         state_n = ST_WAIT_VB;
        end
      end
      ST_WAIT_VB: begin
        if (frame_tick_c) begin
          state_n = ST_FADE_OUT;
          cnt_n   = '0;
        end
      end
      ST_FADE_OUT: begin
        if (frame_tick_c) begin
          if (cnt == CNT_LAST) begin
            cnt_n  = '0;
            fade_n = fade - 5'd1;
            if (fade == 5'd1) state_n = ST_SWAP;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      ST_SWAP: begin
        bg_sel_n = target;
        cnt_n    = '0;
        state_n  = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (frame_tick_c) begin
          if (cnt == CNT_LAST) begin
            cnt_n  = '0;
            fade_n = fade + 5'd1;
            if (fade == FADE_FULL - 5'd1) begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and control registers; handshake flags track the next state so they stay registered
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      fade      <= FADE_FULL;
      cnt       <= '0;
      target    <= '0;
      bg_sel    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_n;
      fade      <= fade_n;
      cnt       <= cnt_n;
      target    <= target_n;
      bg_sel    <= bg_sel_n;
      done      <= done_n;
      busy      <= (state_n != ST_IDLE);
      req_ready <= (state_n == ST_IDLE);
    end
  end

  logic [3:0] red_c, green_c, blue_c;

  bg_fade_scaler u_scale_r (.chan_in(red_in),   .fade(fade), .chan_c(red_c));
  bg_fade_scaler u_scale_g (.chan_in(green_in), .fade(fade), .chan_c(green_c));
  bg_fade_scaler u_scale_b (.chan_in(blue_in),  .fade(fade), .chan_c(blue_c));

  // Registered colour output, forced black outside the active display
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= blank ? red_c   : 4'h0;
      green <= blank ? green_c : 4'h0;
      blue  <= blank ? blue_c  : 4'h0;
    end
  end

endmodule

// File: tb/tb_bg_fade_controller.sv
// Directed bench for bg_fade_controller: default instance plus a 3-level, 1-frame-per-step
// instance used for request clamping.
module tb_bg_fade_controller;

  logic       vga_clk;
  logic       reset;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic       req_valid;
  logic [1:0] req_level;
  logic       req_ready, busy, done;
  logic [1:0] bg_sel;
  logic [3:0] red_in, green_in, blue_in;
  logic [3:0] red, green, blue;

  logic       req_valid3;
  logic [1:0] req_level3;
  logic       req_ready3, busy3, done3;
  logic [1:0] bg_sel3;
  logic [3:0] red3, green3, blue3;

  int total;
  int bad;
  int done_cnt;
  int done3_cnt;
  int busy_seen;

  bg_fade_controller dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .req_valid(req_valid), .req_level(req_level), .req_ready(req_ready),
    .bg_sel(bg_sel), .busy(busy), .done(done),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(red), .green(green), .blue(blue)
  );

  bg_fade_controller #(.NUM_LEVELS(3), .FRAMES_PER_STEP(1)) dut3 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .req_valid(req_valid3), .req_level(req_level3), .req_ready(req_ready3),
    .bg_sel(bg_sel3), .busy(busy3), .done(done3),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(red3), .green(green3), .blue(blue3)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    if (done)  done_cnt  = done_cnt + 1;
    if (done3) done3_cnt = done3_cnt + 1;
    if (busy)  busy_seen = busy_seen + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // One frame tick: raster at (0,480) for one cycle, then moves on
  task automatic tick();
    DrawY = 10'd480;
    DrawX = 10'd0;
    step();
    DrawY = 10'd0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0h exp=1", req_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
    total++; if (bg_sel !== 2'd0)    begin bad++; $display("FAIL reset_bg_sel got=%0h exp=0", bg_sel); end
    total++; if (red !== 4'h0)       begin bad++; $display("FAIL reset_red got=%0h exp=0", red); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_colour();
    red_in = 4'hF; green_in = 4'hA; blue_in = 4'h3; blank = 1'b1;
    step();
    total++; if (red !== 4'hF)   begin bad++; $display("FAIL colour_red got=%0h exp=f", red); end
    total++; if (green !== 4'hA) begin bad++; $display("FAIL colour_green got=%0h exp=a", green); end
    total++; if (blue !== 4'h3)  begin bad++; $display("FAIL colour_blue got=%0h exp=3", blue); end
    blank = 1'b0;
    step();
    total++; if (red !== 4'h0)   begin bad++; $display("FAIL blank_red got=%0h exp=0", red); end
    total++; if (green !== 4'h0) begin bad++; $display("FAIL blank_green got=%0h exp=0", green); end
    blank = 1'b1;
    step();
    total++; if (red !== 4'hF)   begin bad++; $display("FAIL unblank_red got=%0h exp=f", red); end
  endtask

  task automatic test_same_level();
    busy_seen = 0;
    done_cnt  = 0;
    req_level = 2'd0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL same_done got=%0h exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL same_busy got=%0h exp=0", busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL same_done_drop got=%0h exp=0", done); end
    step();
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL same_busy_seen got=%0d exp=0", busy_seen); end
    total++; if (done_cnt !== 1)  begin bad++; $display("FAIL same_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (red !== 4'hF)    begin bad++; $display("FAIL same_no_fade got=%0h exp=f", red); end
  endtask

  // Level 0 -> 2, with a stray request injected during fade-in
  task automatic test_full_transition();
    done_cnt  = 0;
    req_level = 2'd2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL full_busy got=%0h exp=1", busy); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0h exp=0", req_ready); end
    tick();
    total++; if (red !== 4'hF) begin bad++; $display("FAIL full_enter_red got=%0h exp=f", red); end
    ticks(16);
    total++; if (red !== 4'h7) begin bad++; $display("FAIL full_fade8_red got=%0h exp=7", red); end
    ticks(15);
    total++; if (bg_sel !== 2'd0) begin bad++; $display("FAIL full_sel_early got=%0h exp=0", bg_sel); end
    total++; if (red !== 4'h0)    begin bad++; $display("FAIL full_fade1_red got=%0h exp=0", red); end
    tick();
    total++; if (bg_sel !== 2'd2) begin bad++; $display("FAIL full_swap_sel got=%0h exp=2", bg_sel); end
    ticks(8);
    total++; if (red !== 4'h3) begin bad++; $display("FAIL full_fadein4_red got=%0h exp=3", red); end
    req_level = 2'd3;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ignore_ready got=%0h exp=0", req_ready); end
    ticks(23);
    total++; if (red !== 4'hE)  begin bad++; $display("FAIL full_fadein15_red got=%0h exp=e", red); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL full_early_done got=%0d exp=0", done_cnt); end
    tick();
    total++; if (done_cnt !== 1)     begin bad++; $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL full_busy_end got=%0h exp=0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_ready_end got=%0h exp=1", req_ready); end
    total++; if (bg_sel !== 2'd2)    begin bad++; $display("FAIL ignore_sel got=%0h exp=2", bg_sel); end
    total++; if (red !== 4'hF)       begin bad++; $display("FAIL full_red_end got=%0h exp=f", red); end
  endtask

  // Stalled raster yields one tick; then abort by reset at fade=7
  task automatic test_stall_and_abort();
    req_level = 2'd1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    DrawY = 10'd480;
    DrawX = 10'd0;
    for (int i = 0; i < 10; i++) step();
    DrawY = 10'd0;
    step();
    total++; if (red !== 4'hF) begin bad++; $display("FAIL stall_red got=%0h exp=f", red); end
    tick();
    total++; if (red !== 4'hF) begin bad++; $display("FAIL stall_tick1_red got=%0h exp=f", red); end
    tick();
    total++; if (red !== 4'hE) begin bad++; $display("FAIL stall_tick2_red got=%0h exp=e", red); end
    ticks(16);
    total++; if (red !== 4'h6) begin bad++; $display("FAIL abort_fade7_red got=%0h exp=6", red); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy got=%0h exp=0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0h exp=1", req_ready); end
    total++; if (bg_sel !== 2'd0)    begin bad++; $display("FAIL abort_sel got=%0h exp=0", bg_sel); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL abort_done got=%0h exp=0", done); end
    reset = 1'b0;
    step();
    step();
    total++; if (red !== 4'hF)   begin bad++; $display("FAIL abort_fade16_red got=%0h exp=f", red); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_clamp();
    done3_cnt  = 0;
    req_level3 = 2'd3;
    req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL clamp_busy got=%0h exp=1", busy3); end
    ticks(33);
    total++; if (bg_sel3 !== 2'd2) begin bad++; $display("FAIL clamp_sel got=%0h exp=2", bg_sel3); end
    total++; if (done3_cnt !== 1)  begin bad++; $display("FAIL clamp_done_cnt got=%0d exp=1", done3_cnt); end
    total++; if (busy3 !== 1'b0)   begin bad++; $display("FAIL clamp_busy_end got=%0h exp=0", busy3); end
  endtask

  initial begin
    total = 0; bad = 0; done_cnt = 0; done3_cnt = 0; busy_seen = 0;
    reset = 1'b1;
    DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
    req_valid = 1'b0; req_level = 2'd0;
    req_valid3 = 1'b0; req_level3 = 2'd0;
    red_in = 4'h0; green_in = 4'h0; blue_in = 4'h0;

    test_reset();
    test_colour();
    test_same_level();
    test_full_transition();
    test_stall_and_abort();
    test_clamp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
